// File: rtl/seg_scan_pkg.sv
// Shared definitions for the multiplexed 8-digit seven-segment scanner:
// FSM state encoding, default timing values, segment codes and buffer layout.
package seg_scan_pkg;

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  localparam logic [15:0] DIV_MAX_DEF      = 16'd49999;
  localparam logic [7:0]  BLANK_CYCLES_DEF = 8'd64;

  // Active-low segment codes, bit0..6 = a..g
  localparam logic [6:0] SEG_HEX_0 = 7'h40;
  localparam logic [6:0] SEG_HEX_1 = 7'h79;
  localparam logic [6:0] SEG_HEX_2 = 7'h24;
  localparam logic [6:0] SEG_HEX_3 = 7'h30;
  localparam logic [6:0] SEG_HEX_4 = 7'h19;
  localparam logic [6:0] SEG_HEX_5 = 7'h12;
  localparam logic [6:0] SEG_HEX_6 = 7'h02;
  localparam logic [6:0] SEG_HEX_7 = 7'h78;
  localparam logic [6:0] SEG_HEX_8 = 7'h00;
  localparam logic [6:0] SEG_HEX_9 = 7'h10;
  localparam logic [6:0] SEG_HEX_A = 7'h08;
  localparam logic [6:0] SEG_HEX_B = 7'h03;
  localparam logic [6:0] SEG_HEX_C = 7'h46;
  localparam logic [6:0] SEG_HEX_D = 7'h21;
  localparam logic [6:0] SEG_HEX_E = 7'h06;
  localparam logic [6:0] SEG_HEX_F = 7'h0E;

  typedef struct packed {
    logic [31:0] digits;
    logic [7:0]  dp;
    logic [7:0]  en;
  } disp_buf_t;

  function automatic logic [7:0] digit_select(input logic [2:0] idx);
    return ~(8'h01 << idx);
  endfunction

endpackage

// File: rtl/seg_scan_if.sv
// Load handshake and display drive bundle between a requester and the scanner.
interface seg_scan_if;

  logic [31:0] digits_in;
  logic [7:0]  dp_in;
  logic [7:0]  digit_en;
  logic        load;
  logic        load_ack;
  logic [7:0]  selector;
  logic [7:0]  seg;
  logic        frame_start;

  modport master (
    output digits_in, dp_in, digit_en, load,
    input  load_ack, selector, seg, frame_start
  );

  modport slave (
    input  digits_in, dp_in, digit_en, load,
    output load_ack, selector, seg, frame_start
  );

endinterface

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern (bit0..6 = a..g).
module seg_hex_decode
  import seg_scan_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = 7'h7F;
    case (hex)
      4'h0: seg_n = SEG_HEX_0;
      4'h1: seg_n = SEG_HEX_1;
      4'h2: seg_n = SEG_HEX_2;
      4'h3: seg_n = SEG_HEX_3;
      4'h4: seg_n = SEG_HEX_4;
      4'h5: seg_n = SEG_HEX_5;
      4'h6: seg_n = SEG_HEX_6;
      4'h7: seg_n = SEG_HEX_7;
      4'h8: seg_n = SEG_HEX_8;
      4'h9: seg_n = SEG_HEX_9;
      4'hA: seg_n = SEG_HEX_A;
      4'hB: seg_n = SEG_HEX_B;
      4'hC: seg_n = SEG_HEX_C;
      4'hD: seg_n = SEG_HEX_D;
      4'hE: seg_n = SEG_HEX_E;
      4'hF: seg_n = SEG_HEX_F;
      default: seg_n = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 8-digit seven-segment scanner with a frame-synchronous
// display buffer; every output is registered from the next-state values.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter logic [15:0] DIV_MAX      = DIV_MAX_DEF,
  parameter logic [7:0]  BLANK_CYCLES = BLANK_CYCLES_DEF
)
(
  input  logic       systclk,
  input  logic       reset,
  seg_scan_if.slave  bus
);

  localparam logic        NO_BLANK   = (BLANK_CYCLES == 8'd0);
  localparam logic [15:0] BLANK_LAST = NO_BLANK ? 16'd0 : ({8'd0, BLANK_CYCLES} - 16'd1);

  logic        run;
  logic [0:0]  state, state_nxt;
  logic [2:0]  idx, idx_nxt;
  logic [15:0] cnt, cnt_nxt;
  disp_buf_t   dbuf, dbuf_nxt;

  logic        boundary;
  logic        capture;
  logic        lit;
  logic [3:0]  nibble;
  logic [6:0]  seg_code;

  logic [7:0]  selector_p0, selector_p1;
  logic [7:0]  seg_p0, seg_p1;
  logic        load_ack_p0, load_ack_p1;
  logic        frame_start_p0, frame_start_p1;

  // The first edge after reset release starts slot 0, so frame_start can mark it.
  always_comb begin
    boundary  = run && (state == ST_SHOW) && (cnt == DIV_MAX) && (idx == 3'd7);
    capture   = boundary && bus.load;
    dbuf_nxt  = capture ? {bus.digits_in, bus.dp_in, bus.digit_en} : dbuf;
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    if (!run) begin
      state_nxt = NO_BLANK ? ST_SHOW : ST_BLANK;
      idx_nxt   = 3'd0;
      cnt_nxt   = 16'd0;
    end else if (state == ST_BLANK) begin
      if (cnt == BLANK_LAST) begin
        state_nxt = ST_SHOW;
        cnt_nxt   = 16'd0;
      end else begin
        cnt_nxt = cnt + 16'd1;
      end
    end else begin
      if (cnt == DIV_MAX) begin
        idx_nxt   = idx + 3'd1;
        cnt_nxt   = 16'd0;
        state_nxt = NO_BLANK ? ST_SHOW : ST_BLANK;
      end else begin
        cnt_nxt = cnt + 16'd1;
      end
    end
  end

  // Stage p0: output values for the cycle the next state describes
  assign nibble = dbuf_nxt.digits[{idx_nxt, 2'b00} +: 4];

  seg_hex_decode u_dec (
    .hex   (nibble),
    .seg_n (seg_code)
  );

  always_comb begin
    lit            = (state_nxt == ST_SHOW) && dbuf_nxt.en[idx_nxt];
    selector_p0    = lit ? digit_select(idx_nxt) : 8'hFF;
    seg_p0         = lit ? {~dbuf_nxt.dp[idx_nxt], seg_code} : 8'hFF;
    load_ack_p0    = capture;
    frame_start_p0 = !run || boundary;
  end

  // Stage p1: registered state and outputs
  always_ff @(posedge systclk or negedge reset) begin
    if (!reset) begin
      run            <= 1'b0;
      state          <= ST_BLANK;
      idx            <= 3'd0;
      cnt            <= 16'd0;
      dbuf           <= '0;
      selector_p1    <= 8'hFF;
      seg_p1         <= 8'hFF;
      load_ack_p1    <= 1'b0;
      frame_start_p1 <= 1'b0;
    end else begin
      run            <= 1'b1;
      state          <= state_nxt;
      idx            <= idx_nxt;
      cnt            <= cnt_nxt;
      dbuf           <= dbuf_nxt;
      selector_p1    <= selector_p0;
      seg_p1         <= seg_p0;
      load_ack_p1    <= load_ack_p0;
      frame_start_p1 <= frame_start_p0;
    end
  end

  assign bus.selector    = selector_p1;
  assign bus.seg         = seg_p1;
  assign bus.load_ack    = load_ack_p1;
  assign bus.frame_start = frame_start_p1;

endmodule
